// File: rtl/ats21_cmd_frontend.sv
// ATS21 command front end: two-word capture for clients A and B, one holding slot each,
// and arbitration onto a single valid/ready instruction stream for the core.
module ats21_cmd_frontend #(
    parameter bit RR_ARB = 1'b1,
    parameter int WORD_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [WORD_W-1:0]     ctrlA,
    input  logic [WORD_W-1:0]     ctrlB,
    output logic                  busy,
    output logic                  ovf_a,
    output logic                  ovf_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WORD_W-1:0]   out_instr,
    output logic                  out_src
);

    localparam int IW = 2 * WORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        LOW  = 1'b1
    } cap_state_e;

    cap_state_e        cap_q    [2];
    cap_state_e        cap_d    [2];
    logic [WORD_W-1:0] hi_q     [2];
    logic [WORD_W-1:0] hi_d     [2];
    logic [IW-1:0]     slot_q   [2];
    logic [IW-1:0]     slot_d   [2];
    logic [WORD_W-1:0] ctrl     [2];
    logic [1:0]        slot_v_q;
    logic [1:0]        slot_v_d;
    logic [1:0]        ovf_q;
    logic [1:0]        ovf_d;
    logic [1:0]        drain;
    logic              rr_q;
    logic              rr_d;
    logic              lock_q;
    logic              lock_d;
    logic              lock_src_q;
    logic              lock_src_d;
    logic              grant;
    logic              hs;

    assign ctrl[0] = ctrlA;
    assign ctrl[1] = ctrlB;

    // A presented-but-stalled grant is frozen so the core never sees the instruction change under it.
    always_comb begin
        grant = 1'b0;
        if (lock_q) begin
            grant = lock_src_q;
        end else if (slot_v_q[0] && slot_v_q[1]) begin
            grant = RR_ARB ? rr_q : 1'b0;
        end else begin
            grant = slot_v_q[1] & ~slot_v_q[0];
        end
    end

    assign hs       = out_valid & out_ready;
    assign drain[0] = hs & ~grant;
    assign drain[1] = hs & grant;

    // Index 0 is client A, index 1 is client B; both run the identical two-word capture.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cap_d[i]    = cap_q[i];
            hi_d[i]     = hi_q[i];
            slot_d[i]   = slot_q[i];
            slot_v_d[i] = slot_v_q[i] & ~drain[i];
            ovf_d[i]    = 1'b0;
            case (cap_q[i])
                IDLE: begin
                    if (req && (ctrl[i][WORD_W-1 -: 3] != 3'b000)) begin
                        cap_d[i] = LOW;
                        hi_d[i]  = ctrl[i];
                    end
                end
                LOW: begin
                    cap_d[i] = IDLE;
                    if (slot_v_q[i] && !drain[i]) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        slot_d[i]   = {hi_q[i], ctrl[i]};
                        slot_v_d[i] = 1'b1;
                    end
                end
                default: cap_d[i] = IDLE;
            endcase
        end
    end

    // rr_q names the client favoured next when both slots are full.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = out_valid & ~out_ready;
        lock_src_d = grant;
        if (hs) begin
            rr_d = ~grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                cap_q[i]  <= IDLE;
                hi_q[i]   <= '0;
                slot_q[i] <= '0;
            end
            slot_v_q   <= '0;
            ovf_q      <= '0;
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cap_q[i]  <= cap_d[i];
                hi_q[i]   <= hi_d[i];
                slot_q[i] <= slot_d[i];
            end
            slot_v_q   <= slot_v_d;
            ovf_q      <= ovf_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

    assign out_valid = |slot_v_q;
    assign out_instr = slot_q[grant];
    assign out_src   = grant;
    assign ovf_a     = ovf_q[0];
    assign ovf_b     = ovf_q[1];
    assign busy      = (cap_q[0] == LOW) | (cap_q[1] == LOW) | out_valid;

endmodule

// File: tb/tb_ats21_cmd_frontend.sv
// Self-checking bench for ats21_cmd_frontend: scoreboard of expected {src, instr} handshakes
// plus per-scenario inline checks of latency, lock, overflow and reset behaviour.
module tb_ats21_cmd_frontend;

    logic        clk;
    logic        reset;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        busy;
    logic        ovf_a;
    logic        ovf_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_src;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ovf_a_cnt = 0;
    int          ovf_b_cnt = 0;
    logic [32:0] exp_q[$];

    ats21_cmd_frontend #(.RR_ARB(1'b1), .WORD_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ctrlA     (ctrlA),
        .ctrlB     (ctrlB),
        .busy      (busy),
        .ovf_a     (ovf_a),
        .ovf_b     (ovf_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake must match the oldest expected {src, instr}.
    always @(negedge clk) begin
        if (!reset) begin
            if (ovf_a) ovf_a_cnt++;
            if (ovf_b) ovf_b_cnt++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_output got src=%0d instr=%08h, expected none", out_src, out_instr);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({out_src, out_instr} !== e) begin
                        n_fail++;
                        $display("[TB] FAIL scoreboard got src=%0d instr=%08h, expected src=%0d instr=%08h",
                                 out_src, out_instr, e[32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req   = 1'b0;
        ctrlA = 16'h0000;
        ctrlB = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        n_checks++; if (ovf_a !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_ovf_a got %b expected 0", ovf_a); end
        n_checks++; if (ovf_b !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_ovf_b got %b expected 0", ovf_b); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b expected 0", out_valid); end
        n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr got %08h expected 0", out_instr); end
        n_checks++; if (out_src !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_src got %b expected 0", out_src); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b1;
        req = 1'b1; ctrlA = 16'h2000; ctrlB = 16'h2240;
        exp_q.push_back({1'b0, 32'h20000000});
        exp_q.push_back({1'b1, 32'h22400000});
        step();
        n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("[TB] FAIL sim_busy_low got %b expected 1", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sim_early_valid got %b expected 0", out_valid); end
        idle_inputs();
        step();
        n_checks++; if ({out_valid, out_src, out_instr} !== {1'b1, 1'b0, 32'h20000000})
            begin n_fail++; $display("[TB] FAIL sim_t2 got v=%b src=%b instr=%08h expected v=1 src=0 instr=20000000", out_valid, out_src, out_instr); end
        step();
        n_checks++; if ({out_valid, out_src, out_instr} !== {1'b1, 1'b1, 32'h22400000})
            begin n_fail++; $display("[TB] FAIL sim_t3 got v=%b src=%b instr=%08h expected v=1 src=1 instr=22400000", out_valid, out_src, out_instr); end
        step();
        n_checks++; if ({busy, out_valid} !== 2'b00)
            begin n_fail++; $display("[TB] FAIL sim_t4_busy got busy=%b valid=%b expected 0 0", busy, out_valid); end
        n_checks++; if (exp_q.size() != 0)
            begin n_fail++; $display("[TB] FAIL sim_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_staggered();
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 32'h26000000});
        exp_q.push_back({1'b1, 32'h28400000});
        req = 1'b1; ctrlA = 16'h2600; ctrlB = 16'h0000;
        step();
        req = 1'b1; ctrlA = 16'h0000; ctrlB = 16'h2840;
        step();
        n_checks++; if ({out_valid, out_src, out_instr} !== {1'b1, 1'b0, 32'h26000000})
            begin n_fail++; $display("[TB] FAIL stag_a got v=%b src=%b instr=%08h expected v=1 src=0 instr=26000000", out_valid, out_src, out_instr); end
        idle_inputs();
        step();
        n_checks++; if ({out_valid, out_src, out_instr} !== {1'b1, 1'b1, 32'h28400000})
            begin n_fail++; $display("[TB] FAIL stag_b got v=%b src=%b instr=%08h expected v=1 src=1 instr=28400000", out_valid, out_src, out_instr); end
        step();
        n_checks++; if (exp_q.size() != 0)
            begin n_fail++; $display("[TB] FAIL stag_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_single();
        int a0 = ovf_a_cnt;
        int b0 = ovf_b_cnt;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 32'hA0800025});
        req = 1'b1; ctrlA = 16'hA080; ctrlB = 16'h0000;
        step();
        req = 1'b0; ctrlA = 16'h0025; ctrlB = 16'h0000;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (exp_q.size() != 0)
            begin n_fail++; $display("[TB] FAIL single_drain got %0d pending expected 0", exp_q.size()); end
        n_checks++; if ((ovf_a_cnt - a0) + (ovf_b_cnt - b0) != 0)
            begin n_fail++; $display("[TB] FAIL single_ovf got %0d pulses expected 0", (ovf_a_cnt - a0) + (ovf_b_cnt - b0)); end
    endtask

    task automatic test_backpressure();
        int held_bad = 0;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hC1020010});
        exp_q.push_back({1'b1, 32'h22400000});
        req = 1'b1; ctrlA = 16'hC102;
        step();
        req = 1'b0; ctrlA = 16'h0010;
        step();
        ctrlA = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            case (i)
                1:       begin req = 1'b1; ctrlB = 16'h2240; end
                default: begin req = 1'b0; ctrlB = 16'h0000; end
            endcase
            if ({out_valid, out_src, out_instr} !== {1'b1, 1'b0, 32'hC1020010}) held_bad++;
            step();
        end
        n_checks++; if ({out_valid, out_src, out_instr} !== {1'b1, 1'b0, 32'hC1020010})
            begin n_fail++; $display("[TB] FAIL bp_lock got v=%b src=%b instr=%08h expected v=1 src=0 instr=c1020010", out_valid, out_src, out_instr); end
        n_checks++; if (held_bad != 0)
            begin n_fail++; $display("[TB] FAIL bp_hold got %0d unstable cycles expected 0", held_bad); end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        n_checks++; if (exp_q.size() != 0)
            begin n_fail++; $display("[TB] FAIL bp_drain got %0d pending expected 0", exp_q.size()); end
        step();
    endtask

    task automatic test_overflow();
        int a0 = ovf_a_cnt;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hA0800025});
        req = 1'b1; ctrlA = 16'hA080; step();
        req = 1'b0; ctrlA = 16'h0025; step();
        req = 1'b1; ctrlA = 16'hC102; step();
        req = 1'b0; ctrlA = 16'h0010; step();
        idle_inputs();
        n_checks++; if (ovf_a !== 1'b1)
            begin n_fail++; $display("[TB] FAIL ovf_pulse got %b expected 1", ovf_a); end
        step();
        n_checks++; if (ovf_a !== 1'b0)
            begin n_fail++; $display("[TB] FAIL ovf_one_cycle got %b expected 0", ovf_a); end
        n_checks++; if ({out_valid, out_instr} !== {1'b1, 32'hA0800025})
            begin n_fail++; $display("[TB] FAIL ovf_keep got v=%b instr=%08h expected v=1 instr=a0800025", out_valid, out_instr); end
        n_checks++; if (ovf_a_cnt - a0 != 1)
            begin n_fail++; $display("[TB] FAIL ovf_count got %0d expected 1", ovf_a_cnt - a0); end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        step();

        // Second pass: the stalled slot drains in the very cycle the new word lands.
        a0 = ovf_a_cnt;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hA0800025});
        exp_q.push_back({1'b0, 32'hC1020010});
        req = 1'b1; ctrlA = 16'hA080; step();
        req = 1'b0; ctrlA = 16'h0025; step();
        req = 1'b1; ctrlA = 16'hC102; step();
        req = 1'b0; ctrlA = 16'h0010; out_ready = 1'b1; step();
        idle_inputs();
        n_checks++; if ({out_valid, out_instr} !== {1'b1, 32'hC1020010})
            begin n_fail++; $display("[TB] FAIL ovf_b2b got v=%b instr=%08h expected v=1 instr=c1020010", out_valid, out_instr); end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        step();
        n_checks++; if (exp_q.size() != 0 || ovf_a_cnt != a0)
            begin n_fail++; $display("[TB] FAIL ovf_noovf got pending=%0d pulses=%0d expected 0 0", exp_q.size(), ovf_a_cnt - a0); end
    endtask

    task automatic test_reset_midop();
        int a0 = ovf_a_cnt;
        int b0 = ovf_b_cnt;
        out_ready = 1'b1;
        req = 1'b1; ctrlA = 16'hA080; ctrlB = 16'h2240;
        step();
        req = 1'b0; ctrlA = 16'h0025; ctrlB = 16'h0000; reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        n_checks++; if ({out_valid, busy, ovf_a, ovf_b} !== 4'b0000)
            begin n_fail++; $display("[TB] FAIL midop_reset got v=%b busy=%b ovf=%b%b expected 0 0 00", out_valid, busy, ovf_a, ovf_b); end
        for (int i = 0; i < 4; i++) step();
        n_checks++; if ((ovf_a_cnt - a0) + (ovf_b_cnt - b0) != 0 || out_valid !== 1'b0)
            begin n_fail++; $display("[TB] FAIL midop_after got pulses=%0d v=%b expected 0 0", (ovf_a_cnt - a0) + (ovf_b_cnt - b0), out_valid); end
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_simultaneous();
        test_staggered();
        test_single();
        test_backpressure();
        test_overflow();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ats21_cmd_frontend.md
Name: ats21_cmd_frontend

Overview:
- Input front end of ATS21. Deserialises the two 16-bit client control buses (ctrlA, ctrlB) into 32-bit instructions, following the req-based two-word protocol.
- Holds one completed instruction per client.
- Arbitrates the held instructions onto a single valid/ready instruction stream that feeds the ATS21 decode/execute core.

Parameters:
- RR_ARB, 1: 1 = round-robin arbitration between clients; 0 = fixed priority, A over B.
- WORD_W, 16: client bus width. Instruction width is 2*WORD_W. Opcode is bits [WORD_W-1:WORD_W-3] of the first word.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  1  request strobe shared by both clients
- ctrlA  in  WORD_W  client A control word
- ctrlB  in  WORD_W  client B control word
- busy  out  1  high while any capture is in progress or any slot is occupied
- ovf_a  out  1  one-cycle pulse: a client A instruction was dropped
- ovf_b  out  1  one-cycle pulse: a client B instruction was dropped
- out_valid  out  1  instruction available to the core
- out_ready  in  1  core accepts the instruction this cycle
- out_instr  out  2*WORD_W  {first word, second word}
- out_src  out  1  source client: 0 = A, 1 = B

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - busy=0, ovf_a=0, ovf_b=0, out_valid=0, out_instr=0, out_src=0.
  - Capture FSMs go to IDLE. Slots are emptied. The RR pointer favours A next. The grant lock is cleared.
- Per-client capture FSM (independent for A and B): states IDLE, LOW.
  - IDLE -> LOW when req=1 and ctrlX[15:13] != 000. The upper word is registered.
  - IDLE with req=0, or with opcode 000 (Nop/idle marker): stay in IDLE, nothing captured.
  - LOW -> IDLE unconditionally on the next cycle. ctrlX is registered as the lower word regardless of req or value.
  - While in LOW, the start condition is not evaluated for that client.
- Staggered protocol:
  - req high at T with A opcode != 0 and B opcode 000: A starts at T.
  - req still high at T+1 with B opcode != 0: B starts at T+1.
  - A completes at T+1; B completes at T+2.
  - Simultaneous start of both clients at T is legal; both complete at T+1.
- Slot write: on the LOW cycle, the assembled {hi, lo} is written to slot X and becomes visible from the next cycle.
  - Latency: req edge at T -> out_valid can be high at T+2 at the earliest.
- Overflow:
  - If slot X is full at the LOW cycle and is not being drained by an out handshake that same cycle, the new instruction is discarded.
  - ovf_X pulses high for one cycle, registered, i.e. the cycle after the LOW cycle.
  - If slot X is drained in the same cycle, the new instruction is written (back-to-back, no bubble).
- Output:
  - out_valid = slotA_v | slotB_v. out_instr and out_src come from the granted slot.
  - Handshake occurs when out_valid & out_ready. The granted slot is cleared at that posedge.
- Arbitration:
  - Only one slot full: grant that slot.
  - Both full, RR_ARB=1: grant the client not served last. The pointer updates only on handshake.
  - Both full, RR_ARB=0: grant A.
- Stability:
  - While out_valid=1 and out_ready=0, the grant is locked. out_instr and out_src must not change even if the other slot fills.
  - The lock releases on handshake.
- busy = (either FSM in LOW) | slotA_v | slotB_v.
- Reset asserted mid-capture or with full slots: everything is discarded at that posedge, and no ovf pulse is generated.
- Contents of unused instruction fields are passed through unmodified. No decode is done here.

Test Plan:
- Simultaneous set_clock:
  - Stimulus: req=1 with ctrlA=0x2000, ctrlB=0x2240; next cycle req=0 with ctrlA=0x0000, ctrlB=0x0000; out_ready=1.
  - Required: out_valid from T+2; out_instr=0x20000000, src=0 at T+2; then 0x22400000, src=1 at T+3; busy low at T+4.
- Single client, other Nop:
  - Stimulus: ctrlA=0xA080 then 0x0025, ctrlB=0x0000 both cycles.
  - Required: exactly one output 0xA0800025, src=0; ovf_a=ovf_b=0.
- Staggered:
  - Stimulus: T: req=1, A=0x2600, B=0x0000. T+1: req=1, A=0x0000, B=0x2840. T+2: req=0, B=0x0000.
  - Required: A instruction 0x26000000 presented at T+2; B instruction 0x28400000 presented at T+3.
- Backpressure and lock:
  - Stimulus: out_ready=0; send A=0xC102/0x0010, then two cycles later B=0x2240/0x0000.
  - Required: out_instr stays 0xC1020010, src=0 throughout. Raising out_ready drains A, then B.
- Overflow:
  - Stimulus: out_ready=0; send two A instructions back-to-back, 0xA080/0x0025 then 0xC102/0x0010.
  - Required: ovf_a pulses one cycle; the slot holds 0xA0800025. The same sequence with out_ready=1 gives no ovf.
- Reset mid-op:
  - Stimulus: assert reset in the LOW cycle of a capture.
  - Required: out_valid=0 and busy=0 next cycle; no instruction emitted; no ovf pulse.
